xip_flash_responder: RTL and testbench



---
 rtl/xip_flash_responder_pkg.sv | 29 ++
 rtl/xip_flash_responder_if.sv | 28 ++
 rtl/xip_flash_byteshift.sv | 36 +++
 rtl/xip_flash_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_xip_flash_responder.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/xip_flash_responder_pkg.sv
// Shared definitions for the XIP serial-flash responder: state encoding,
// opcode constants, default widths and the byte-lane select helper.
package xip_flash_responder_pkg;

  localparam int         XFR_ADDRW    = 24;
  localparam logic [7:0] XFR_CMD_READ = 8'h03;
  localparam logic [7:0] XFR_CMD_FAST = 8'h0B;
  localparam int         XFR_DUMMYW   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_IGNORE = 3'd5
  } xfr_state_e;

  // Little-endian byte lane of a 32-bit memory word.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    lane_byte = w[7:0];
      2'd1:    lane_byte = w[15:8];
      2'd2:    lane_byte = w[23:16];
      default: lane_byte = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/xip_flash_responder_if.sv
// SPI pin and word-memory bundle for the XIP flash responder.
// slave: the responder itself; master: the initiator/memory side.
interface xip_flash_responder_if
  import xip_flash_responder_pkg::*;
#(
  parameter int ADDRW = XFR_ADDRW
);
  logic             cs;
  logic             scl;
  logic             mosi;
  logic             miso;
  logic             misoe;
  logic             mem_rd;
  logic [ADDRW-3:0] mem_addr;
  logic [31:0]      mem_rdata;
  logic             active;
  logic             cmd_err;

  modport slave (
    input  cs, scl, mosi, mem_rdata,
    output miso, misoe, mem_rd, mem_addr, active, cmd_err
  );

  modport master (
    output cs, scl, mosi, mem_rdata,
    input  miso, misoe, mem_rd, mem_addr, active, cmd_err
  );
endinterface

// File: rtl/xip_flash_byteshift.sv
// 8-bit parallel-load / serial-out shifter feeding miso. Loads one byte lane
// of a 32-bit word, shifts left on a data-phase fall, MSB is the output bit.
module xip_flash_byteshift
  import xip_flash_responder_pkg::*;
(
  input  logic        clk,
  input  logic        clr_i,
  input  logic        ld_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic        shift_i,
  output logic        msb_o
);
  logic [7:0] sh_q;
  logic [7:0] sh_d;

  // Clear wins over load, load wins over shift.
  always_comb begin
    sh_d = sh_q;
    if (clr_i) begin
      sh_d = '0;
    end else if (ld_i) begin
      sh_d = lane_byte(word_i, lane_i);
    end else if (shift_i) begin
      sh_d = {sh_q[6:0], 1'b0};
    end
  end

  // Shifter register; contents are qualified by misoe downstream.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign msb_o = sh_q[7];

endmodule

// File: rtl/xip_flash_responder.sv
// SPI mode-0 serial-flash responder for the XIP read path. Decodes READ
// (and FAST READ when XIP_FLASH_RESPONDER_FASTREAD_EN is defined), shifts in
// a 24-bit byte address and streams little-endian bytes from a 32-bit word
// memory with one-cycle read latency, prefetching the next word on lane 3.
// SPI pins share clk with the initiator, so no synchronizers are used.
module xip_flash_responder
  import xip_flash_responder_pkg::*;
#(
  parameter int         ADDRW    = XFR_ADDRW,
  parameter logic [7:0] CMD_READ = XFR_CMD_READ,
  parameter logic [7:0] CMD_FAST = XFR_CMD_FAST,
  parameter int         DUMMYW   = XFR_DUMMYW
) (
  input logic                  clk,
  input logic                  rstb,
  xip_flash_responder_if.slave bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_CMD    = ST_CMD;
  localparam logic [2:0] S_ADDR   = ST_ADDR;
  localparam logic [2:0] S_DUMMY  = ST_DUMMY;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_IGNORE = ST_IGNORE;

  localparam int CW = $clog2((ADDRW > DUMMYW) ? ADDRW : DUMMYW);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [ADDRW-1:0] ADDR_ONE = ADDRW'(1);
  localparam logic [ADDRW-3:0] WORD_ONE = (ADDRW-2)'(1);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic             skip_q, skip_d;
  logic             mem_rd_q, mem_rd_d;
  logic [ADDRW-3:0] mem_addr_q, mem_addr_d;
  logic             rd_init_q, rd_init_d;
  logic             rd_vld_q, rd_vld_init_q;
  logic [31:0]      buf_q;
  logic             cmd_err_q, cmd_err_d;
  logic             cs_q, scl_q;
`ifdef XIP_FLASH_RESPONDER_FASTREAD_EN
  logic             fast_q, fast_d;
`endif

  logic             rise, fall;
  logic             sh_clr, sh_ld, sh_shift, sh_msb;
  logic [1:0]       sh_lane;
  logic [31:0]      sh_word;

  // A chip select that is high masks both edges, so cs wins a tie with scl.
  assign rise = bus.scl & ~scl_q & ~bus.cs;
  assign fall = ~bus.scl & scl_q & ~bus.cs;

  // Next-state, fetch and shifter control for the whole transaction.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    skip_d     = skip_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    rd_init_d  = 1'b0;
    cmd_err_d  = 1'b0;
    sh_clr     = 1'b0;
    sh_ld      = 1'b0;
    sh_shift   = 1'b0;
    sh_lane    = addr_q[1:0];
    sh_word    = buf_q;
`ifdef XIP_FLASH_RESPONDER_FASTREAD_EN
    fast_d     = fast_q;
`endif

    // First word returns: load its start lane; lane 3 needs the next word now.
    if (rd_vld_q && rd_vld_init_q) begin
      sh_ld   = 1'b1;
      sh_word = bus.mem_rdata;
      sh_lane = addr_q[1:0];
      if (addr_q[1:0] == 2'd3) begin
        mem_rd_d   = 1'b1;
        mem_addr_d = mem_addr_q + WORD_ONE;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!bus.cs && cs_q) begin
          state_d = S_CMD;
          cnt_d   = '0;
`ifdef XIP_FLASH_RESPONDER_FASTREAD_EN
          fast_d  = 1'b0;
`endif
        end
      end

      S_CMD: begin
        if (rise) begin
          addr_d = {addr_q[ADDRW-2:0], bus.mosi};
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == CW'(7)) begin
            cnt_d = '0;
            if (addr_d[7:0] == CMD_READ) begin
              state_d = S_ADDR;
            end
`ifdef XIP_FLASH_RESPONDER_FASTREAD_EN
            else if (addr_d[7:0] == CMD_FAST) begin
              state_d = S_ADDR;
              fast_d  = 1'b1;
            end
`else
            else if (addr_d[7:0] == CMD_FAST) begin
              state_d   = S_IGNORE;
              cmd_err_d = 1'b1;
            end
`endif
            else begin
              state_d   = S_IGNORE;
              cmd_err_d = 1'b1;
            end
          end
        end
      end

      S_ADDR: begin
        if (rise) begin
          addr_d = {addr_q[ADDRW-2:0], bus.mosi};
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == CW'(ADDRW-1)) begin
            cnt_d      = '0;
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_d[ADDRW-1:2];
            rd_init_d  = 1'b1;
            state_d    = S_DATA;
            skip_d     = 1'b1;
`ifdef XIP_FLASH_RESPONDER_FASTREAD_EN
            if (fast_q) begin
              state_d = S_DUMMY;
              skip_d  = 1'b0;
            end
`endif
          end
        end
      end

`ifdef XIP_FLASH_RESPONDER_FASTREAD_EN
      S_DUMMY: begin
        if (rise) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CW'(DUMMYW-1)) begin
            cnt_d   = '0;
            state_d = S_DATA;
            skip_d  = 1'b1;
          end
        end
      end
`endif

      S_DATA: begin
        // The fall that closes the last address/dummy bit is not a data shift.
        if (fall) begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else if (cnt_q[2:0] == 3'd7) begin
            cnt_d   = '0;
            addr_d  = addr_q + ADDR_ONE;
            sh_ld   = 1'b1;
            sh_word = buf_q;
            sh_lane = addr_d[1:0];
            if (addr_d[1:0] == 2'd3) begin
              mem_rd_d   = 1'b1;
              mem_addr_d = mem_addr_q + WORD_ONE;
            end
          end else begin
            sh_shift = 1'b1;
            cnt_d    = cnt_q + CNT_ONE;
          end
        end
      end

      default: ;
    endcase

    // Deselect aborts everything; a partial byte is dropped.
    if (bus.cs) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      skip_d     = 1'b0;
      sh_clr     = 1'b1;
      sh_ld      = 1'b0;
      sh_shift   = 1'b0;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      rd_init_d  = 1'b0;
      cmd_err_d  = 1'b0;
    end
  end

  // Control state with synchronous active-low reset; cs_q resets low so a
  // cs held low through reset is not mistaken for a new select.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      skip_q        <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      rd_init_q     <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_vld_init_q <= 1'b0;
      cmd_err_q     <= 1'b0;
      cs_q          <= 1'b0;
      scl_q         <= 1'b0;
`ifdef XIP_FLASH_RESPONDER_FASTREAD_EN
      fast_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      skip_q        <= skip_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      rd_init_q     <= rd_init_d;
      rd_vld_q      <= mem_rd_q & ~bus.cs;
      rd_vld_init_q <= rd_init_q & ~bus.cs;
      cmd_err_q     <= cmd_err_d;
      cs_q          <= bus.cs;
      scl_q         <= bus.scl;
`ifdef XIP_FLASH_RESPONDER_FASTREAD_EN
      fast_q        <= fast_d;
`endif
    end
  end

  // Address shift/byte pointer and the word buffer that catches every fetch.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    if (rd_vld_q) begin
      buf_q <= bus.mem_rdata;
    end
  end

  xip_flash_byteshift u_shift (
    .clk     (clk),
    .clr_i   (sh_clr),
    .ld_i    (sh_ld),
    .lane_i  (sh_lane),
    .word_i  (sh_word),
    .shift_i (sh_shift),
    .msb_o   (sh_msb)
  );

  assign bus.misoe    = (state_q == S_DATA) & ~bus.cs;
  assign bus.miso     = bus.misoe & sh_msb;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.cmd_err  = cmd_err_q;
  assign bus.active   = (state_q == S_CMD) || (state_q == S_ADDR) ||
                        (state_q == S_DUMMY) || (state_q == S_DATA);

endmodule

// File: tb/tb_xip_flash_responder.sv
// Directed bench for xip_flash_responder: mode-0 initiator driving scl with
// a 4-clk period, a 1-cycle-latency word memory and strobe/err/oe monitors.
module tb_xip_flash_responder;
  logic clk = 1'b0;
  logic rstb;
  int   errors = 0;
  int   checks = 0;

  logic [21:0] rd_log[$];
  int          rd_double = 0;
  int          err_cycles = 0;
  int          oe_cycles = 0;
  logic        rd_prev = 1'b0;

  xip_flash_responder_if bus ();

  xip_flash_responder dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    case (a)
      22'h000040: mem_word = 32'h44332211;
      22'h000041: mem_word = 32'h88776655;
      22'h3FFFFF: mem_word = 32'hDDCCBBAA;
      22'h000000: mem_word = 32'h04030201;
      default:    mem_word = {10'h3A5, a};
    endcase
  endfunction

  // Synchronous word memory, one cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem_word(bus.mem_addr);
  end

  // Strobe, error-pulse and drive-enable monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_rd) begin
      rd_log.push_back(bus.mem_addr);
      if (rd_prev) rd_double++;
    end
    rd_prev = bus.mem_rd;
    if (bus.cmd_err) err_cycles++;
    if (bus.misoe) oe_cycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_rd(input logic [21:0] a);
    int n = 0;
    foreach (rd_log[i]) if (rd_log[i] == a) n++;
    return n;
  endfunction

  // One mode-0 bit: mosi set in low phase, miso captured just before the rise.
  task automatic spi_bit(input logic b, output logic r);
    bus.mosi = b;
    @(negedge clk); @(negedge clk);
    r = bus.miso;
    bus.scl = 1'b1;
    @(negedge clk); @(negedge clk);
    bus.scl = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] op, input logic [23:0] a, input int ndummy,
                      input int ndata, output logic [63:0] rx);
    logic r;
    rx = '0;
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(op[i], r);
    for (int i = 23; i >= 0; i--) spi_bit(a[i], r);
    for (int i = 0; i < ndummy; i++) spi_bit(1'b0, r);
    for (int i = 0; i < ndata; i++) begin
      spi_bit(1'b0, r);
      rx = {rx[62:0], r};
    end
    repeat (2) @(negedge clk);
    bus.cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [63:0] rx;
    logic        r;
    int          e0, o0, n0;
    logic [23:0] a_mid;
    logic [7:0]  op_rd;

    bus.cs = 1'b1; bus.scl = 1'b0; bus.mosi = 1'b0; rstb = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", bus.miso, 0);
    check("rst_misoe", bus.misoe, 0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_active", bus.active, 0);
    check("rst_cmd_err", bus.cmd_err, 0);
    rstb = 1'b1;
    repeat (4) @(negedge clk);

    // Aligned READ of word 0x40.
    rd_log.delete();
    xfer(8'h03, 24'h000100, 0, 32, rx);
    check("t1_stream", rx[31:0], 32'h11223344);
    check("t1_le_word", {rx[7:0], rx[15:8], rx[23:16], rx[31:24]}, 32'h44332211);
    check("t1_first_addr", (rd_log.size() > 0) ? rd_log[0] : 22'h3FFFFF, 22'h000040);
    check("t1_rd_w40", n_rd(22'h000040), 1);

    // Unaligned READ crossing into word 0x41.
    rd_log.delete();
    xfer(8'h03, 24'h000102, 0, 48, rx);
    check("t2_stream", rx[47:0], 48'h334455667788);
    check("t2_rd_w40", n_rd(22'h000040), 1);
    check("t2_prefetch_w41", n_rd(22'h000041), 1);

    // Top-of-space READ wrapping to word 0.
    rd_log.delete();
    xfer(8'h03, 24'hFFFFFE, 0, 32, rx);
    check("t3_stream", rx[31:0], 32'hCCDD0102);
    check("t3_rd_top", n_rd(22'h3FFFFF), 1);
    check("t3_wrap_w0", n_rd(22'h000000), 1);

    // Unsupported opcode, then a normal READ.
    rd_log.delete();
    e0 = err_cycles; o0 = oe_cycles;
    xfer(8'h9F, 24'h000100, 0, 16, rx);
    check("t4_cmd_err_pulse", err_cycles - e0, 1);
    check("t4_misoe_low", oe_cycles - o0, 0);
    check("t4_no_fetch", rd_log.size(), 0);
    check("t4_miso_zero", rx[15:0], 16'h0000);
    xfer(8'h03, 24'h000100, 0, 16, rx);
    check("t4_next_read", rx[15:0], 16'h1122);

    // Abort after 3 data bits, then restart elsewhere.
    xfer(8'h03, 24'h000101, 0, 3, rx);
    check("t5_partial", rx[2:0], 3'b001);
    check("t5_idle", bus.active, 0);
    xfer(8'h03, 24'h000105, 0, 16, rx);
    check("t5_new_read", rx[15:0], 16'h6677);

    // Fast read, or rejection of its opcode in the default build.
    e0 = err_cycles; o0 = oe_cycles;
`ifdef XIP_FLASH_RESPONDER_FASTREAD_EN
    xfer(8'h0B, 24'h000100, 8, 32, rx);
    check("t6_fast_stream", rx[31:0], 32'h11223344);
    check("t6_fast_no_err", err_cycles - e0, 0);
`else
    xfer(8'h0B, 24'h000100, 0, 16, rx);
    check("t6_fast_cmd_err", err_cycles - e0, 1);
    check("t6_fast_misoe_low", oe_cycles - o0, 0);
`endif

    // Reset mid-transaction with cs held low.
    op_rd = 8'h03; a_mid = 24'h000100;
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(op_rd[i], r);
    for (int i = 23; i >= 20; i--) spi_bit(a_mid[i], r);
    check("t7_active_mid", bus.active, 1);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("t7_rst_idle", bus.active, 0);
    n0 = rd_log.size(); o0 = oe_cycles;
    for (int i = 19; i >= 0; i--) spi_bit(a_mid[i], r);
    for (int i = 0; i < 16; i++) spi_bit(1'b0, r);
    check("t7_still_idle", bus.active, 0);
    check("t7_no_fetch", rd_log.size() - n0, 0);
    check("t7_misoe_low", oe_cycles - o0, 0);
    bus.cs = 1'b1;
    repeat (4) @(negedge clk);
    xfer(8'h03, 24'h000100, 0, 16, rx);
    check("t7_read_after", rx[15:0], 16'h1122);

    check("mem_rd_single_cycle", rd_double, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
